// File: rtl/busy_table_pkg.sv
// Shared defines for the physical-register busy table: PRF sizing, lane counts and types.
// Optional build macro used by this slice: BUSY_TABLE_WAKE_BYPASS_EN.
package busy_table_pkg;

    localparam int PRF_NUM      = 64;
    localparam int PRF_W        = $clog2(PRF_NUM);
    localparam int CNT_W        = $clog2(PRF_NUM) + 1;
    localparam int SET_LANES    = 2;
    localparam int WAKE_LANES   = 4;
    localparam int ALU_IQ_DEPTH = 8;
    localparam int LOOKUP_PORTS = ALU_IQ_DEPTH + 2;

    typedef logic [PRF_W-1:0]   PRFNum;
    typedef logic [PRF_NUM-1:0] busy_vec_t;
    typedef logic [CNT_W-1:0]   busy_cnt_t;

    function automatic busy_cnt_t popcount(input busy_vec_t vec);
        busy_cnt_t cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < PRF_NUM; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/busy_table_if.sv
// Rename/wakeup/lookup bundle of the busy table; clk and rst are kept as plain ports.
interface busy_table_if;
    import busy_table_pkg::*;

    logic                               flush;
    logic  [SET_LANES-1:0]              set_en;
    PRFNum [SET_LANES-1:0]              set_num;
    logic  [WAKE_LANES-1:0]             clr_en;
    PRFNum [WAKE_LANES-1:0]             clr_num;
    PRFNum [LOOKUP_PORTS-1:0]           rd_num_l;
    PRFNum [LOOKUP_PORTS-1:0]           rd_num_r;
    logic  [LOOKUP_PORTS-1:0]           busyvec_l;
    logic  [LOOKUP_PORTS-1:0]           busyvec_r;
    busy_cnt_t                          busy_cnt;

    modport master (
        output flush, set_en, set_num, clr_en, clr_num, rd_num_l, rd_num_r,
        input  busyvec_l, busyvec_r, busy_cnt
    );

    modport slave (
        input  flush, set_en, set_num, clr_en, clr_num, rd_num_l, rd_num_r,
        output busyvec_l, busyvec_r, busy_cnt
    );

endinterface

// File: rtl/busy_table_lookup.sv
// One combinational busy lookup port; with BUSY_TABLE_WAKE_BYPASS_EN a same-cycle
// wakeup reads not-busy unless a same-cycle allocation of that register is in flight.
module busy_table_lookup
    import busy_table_pkg::*;
(
    input  busy_vec_t              busy_state,
    input  PRFNum                  rd_num,
`ifdef BUSY_TABLE_WAKE_BYPASS_EN
    input  logic  [SET_LANES-1:0]  set_en,
    input  PRFNum [SET_LANES-1:0]  set_num,
    input  logic  [WAKE_LANES-1:0] clr_en,
    input  PRFNum [WAKE_LANES-1:0] clr_num,
`endif
    output logic                   busy
);

`ifdef BUSY_TABLE_WAKE_BYPASS_EN
    logic wake_hit_s;
    logic set_hit_s;

    // Match the looked-up register against every wake and allocate lane this cycle.
    always_comb begin
        wake_hit_s = 1'b0;
        set_hit_s  = 1'b0;
        for (int i = 0; i < WAKE_LANES; i++) begin
            wake_hit_s = wake_hit_s | (clr_en[i] & (clr_num[i] == rd_num));
        end
        for (int i = 0; i < SET_LANES; i++) begin
            set_hit_s = set_hit_s | (set_en[i] & (set_num[i] == rd_num));
        end
        busy = busy_state[rd_num] & ~(wake_hit_s & ~set_hit_s);
    end
`else
    assign busy = busy_state[rd_num];
`endif

endmodule

// File: rtl/busy_table.sv
// Physical-register busy table: set on rename, clear on wakeup, flush-clear, 20 lookups.
// Build option BUSY_TABLE_WAKE_BYPASS_EN adds same-cycle wakeup bypass to the lookups.
module busy_table
    import busy_table_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    busy_table_if.slave  bt
);

    // p0 is the hard-wired zero register and can never become busy.
    localparam busy_vec_t KEEP_MASK = {{(PRF_NUM-1){1'b1}}, 1'b0};

    busy_vec_t                 busy_r;
    busy_vec_t                 busy_next_s;
    busy_vec_t                 set_mask_s;
    busy_vec_t                 clr_mask_s;
    busy_cnt_t                 busy_cnt_r;
    logic [LOOKUP_PORTS-1:0]   busyvec_l_s;
    logic [LOOKUP_PORTS-1:0]   busyvec_r_s;

    // Next state: clears first, sets override them, flush overrides everything.
    always_comb begin
        set_mask_s = {PRF_NUM{1'b0}};
        clr_mask_s = {PRF_NUM{1'b0}};
        for (int i = 0; i < SET_LANES; i++) begin
            set_mask_s[bt.set_num[i]] = set_mask_s[bt.set_num[i]] | bt.set_en[i];
        end
        for (int i = 0; i < WAKE_LANES; i++) begin
            clr_mask_s[bt.clr_num[i]] = clr_mask_s[bt.clr_num[i]] | bt.clr_en[i];
        end
        if (bt.flush) begin
            busy_next_s = {PRF_NUM{1'b0}};
        end else begin
            busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & KEEP_MASK;
        end
    end

    // State and its population count, both cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r     <= {PRF_NUM{1'b0}};
            busy_cnt_r <= {CNT_W{1'b0}};
        end else begin
            busy_r     <= busy_next_s;
            busy_cnt_r <= popcount(busy_next_s);
        end
    end

    for (genvar k = 0; k < LOOKUP_PORTS; k++) begin : g_lookup
        busy_table_lookup u_lookup_l (
            .busy_state (busy_r),
            .rd_num     (bt.rd_num_l[k]),
`ifdef BUSY_TABLE_WAKE_BYPASS_EN
            .set_en     (bt.set_en),
            .set_num    (bt.set_num),
            .clr_en     (bt.clr_en),
            .clr_num    (bt.clr_num),
`endif
            .busy       (busyvec_l_s[k])
        );

        busy_table_lookup u_lookup_r (
            .busy_state (busy_r),
            .rd_num     (bt.rd_num_r[k]),
`ifdef BUSY_TABLE_WAKE_BYPASS_EN
            .set_en     (bt.set_en),
            .set_num    (bt.set_num),
            .clr_en     (bt.clr_en),
            .clr_num    (bt.clr_num),
`endif
            .busy       (busyvec_r_s[k])
        );
    end

    assign bt.busyvec_l = busyvec_l_s;
    assign bt.busyvec_r = busyvec_r_s;
    assign bt.busy_cnt  = busy_cnt_r;

endmodule

// File: doc/busy_table.md
BUSY_TABLE -- requirements
Module: busy_table

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 flush  input  1  pipeline flush; clears every busy bit at the next edge.
REQ-004 set_en[1:0]  input  2  rename allocated a destination physical register on lane 0/1.
REQ-005 set_num[1:0]  input  2 x PRFNum  physical register numbers being allocated.
REQ-006 clr_en[3:0]  input  4  wakeup valid: lanes 0-1 from ALU issue (wake_reg_0/1_en), lane 2 from MDU, lane 3 from LSU.
REQ-007 clr_num[3:0]  input  4 x PRFNum  physical registers being woken.
REQ-008 rd_num_l[9:0]  input  10 x PRFNum  left-operand lookup numbers; 0-7 come from queue slots, 8-9 from enqueue lanes.
REQ-009 rd_num_r[9:0]  input  10 x PRFNum  right-operand lookup numbers, same slot mapping.
REQ-010 busyvec_l[9:0]  output  10  busy bit for each rd_num_l entry.
REQ-011 busyvec_r[9:0]  output  10  busy bit for each rd_num_r entry.
REQ-012 busy_cnt  output  $clog2(PRF_NUM)+1  number of currently busy physical registers.

Function
REQ-013 State SHALL be one busy bit per physical register, PRF_NUM bits in total.
REQ-014 Physical register 0 SHALL read not-busy at all times; set_en targeting 0 SHALL be ignored.
REQ-015 busyvec_l[k]/busyvec_r[k] SHALL be combinational from the state (plus bypass, REQ-026) with zero-cycle latency.
REQ-016 At each edge, the table SHALL set a bit when a set_en lane targets it.
REQ-017 At each edge, the table SHALL clear a bit when a clr_en lane targets it.
REQ-018 If a set and a clear target the same register in one cycle, set SHALL win: the bit is 1 after the edge.
REQ-019 Duplicate set or clear numbers across lanes SHALL behave as a single set or clear.
REQ-020 Setting an already-busy bit or clearing an idle bit SHALL leave that bit unchanged and SHALL raise no error.
REQ-021 When flush is 1, every bit SHALL be 0 after the edge, overriding set and clear in that cycle.
REQ-022 busy_cnt SHALL be a register equal to the popcount of the state after each edge; it SHALL be 0 after flush.
REQ-023 busy_cnt SHALL never exceed PRF_NUM-1.
REQ-024 Lookup ports SHALL be independent; any number of ports MAY query the same register.

Reset
REQ-025 When rst is 0, all busy bits and busy_cnt SHALL clear immediately, asynchronously, and busyvec_l/r SHALL read all zeros. On release, the first update SHALL occur at the next rising edge; a reset mid-flush or mid-set SHALL leave the state all-zero.

Configuration
REQ-026 With BUSY_TABLE_WAKE_BYPASS_EN defined, a lookup whose number matches any clr_en lane in the same cycle SHALL read 0 (not-busy), unless a set_en lane matches the same number that cycle. In that case it SHALL read the stored bit.
REQ-027 Without BUSY_TABLE_WAKE_BYPASS_EN, lookups SHALL reflect only the stored state, so a wakeup becomes visible one cycle after clr_en.

Structure
REQ-028 PRFNum, PRF_NUM, and the wake-lane count constant (4) SHALL live in the shared defines package; the lookup port count (10) SHALL match the ALU issue queue depth plus 2.
REQ-029 One sub-module, busy_table_lookup, SHALL implement a single lookup port with optional bypass; it SHALL be instantiated 20 times.

Verification
REQ-030 Bench SHALL cover: set_en[0]=1, set_num=5; next cycle rd_num_l[0]=5 -> busyvec_l[0]=1 and busy_cnt=1.
REQ-031 Bench SHALL cover: p5 busy; clr_en[2]=1, clr_num=5, rd_num_r[3]=5 the same cycle -> busyvec_r[3]=0 with the macro and 1 without it; 0 in both cases the following cycle.
REQ-032 Bench SHALL cover: set p9 and clear p9 in the same cycle -> p9 busy after the edge, and the bypass reads 1 that cycle.
REQ-033 Bench SHALL cover: set p0 -> busyvec for 0 stays 0 and busy_cnt is unchanged.
REQ-034 Bench SHALL cover: p3, p4 and p7 busy; flush=1 together with set p10 -> all lookups read 0 and busy_cnt=0 after the edge.
REQ-035 Bench SHALL cover: rst asserted low between edges with 6 registers busy -> outputs drop to 0 before the next edge; release -> busy_cnt=0.
